// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared definitions for the 4-stage pipeline hazard controller:
//             ALU opcodes, control-rod bit indices, controller state encodings,
//             PC-select codes and the decoded scoreboard flag record.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // ALU operation field, control rod bits [2:0]
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    // Control rod bit positions
    localparam int CR_BEQ   = 3;
    localparam int CR_RDMEM = 4;
    localparam int CR_MEMWR = 5;
    localparam int CR_REGWR = 6;
    localparam int CR_JMP   = 7;

    // Controller states
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // PC source select
    localparam logic [1:0] PC_SEL_NEXT = 2'd0;
    localparam logic [1:0] PC_SEL_JMP  = 2'd1;
    localparam logic [1:0] PC_SEL_BEQ  = 2'd2;

    // Control bits the scoreboard keeps for each in-flight instruction
    typedef struct packed {
        logic beq;
        logic rdmem;
        logic memwr;
        logic regwr;
    } sb_flags_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Bundle between the pipeline datapath (master) and the hazard
//             controller (slave).
//  Ports    : master drives id_valid, id_ctrl, id_rd, id_rs1, id_rs2,
//             ex_br_taken, mem_ready; slave drives mem_req, stall_if,
//             stall_id, flush_id, pc_sel, mem_timeout.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int RA_W = 3
);
    logic            id_valid;
    logic [7:0]      id_ctrl;
    logic [RA_W-1:0] id_rd;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            ex_br_taken;
    logic            mem_req;
    logic            mem_ready;
    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic [1:0]      pc_sel;
    logic            mem_timeout;

    modport master (
        output id_valid, id_ctrl, id_rd, id_rs1, id_rs2, ex_br_taken, mem_ready,
        input  mem_req, stall_if, stall_id, flush_id, pc_sel, mem_timeout
    );

    modport slave (
        input  id_valid, id_ctrl, id_rd, id_rs1, id_rs2, ex_br_taken, mem_ready,
        output mem_req, stall_if, stall_id, flush_id, pc_sel, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/haz_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : haz_scoreboard
//  Purpose  : 3-entry shift register of in-flight instructions (EX, MEM, WB)
//             plus source-register match logic against the ID instruction.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             advance         - shift the pipe by one stage
//             ins_valid/rd/flags - entry shifted into EX (valid=0 is a bubble)
//             id_rs1, id_rs2  - source registers of the ID instruction
//             raw_hit         - any valid register writer matches a source
//             load_use_hit    - EX holds a load whose rd matches a source
//             mem_memop       - MEM entry is a load or store
//             ex_beq          - EX entry is a branch
//  Revision : 1.0 - initial release
// ============================================================================
module haz_scoreboard
    import pipe_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            advance,
    input  wire logic            ins_valid,
    input  wire logic [RA_W-1:0] ins_rd,
    input  wire sb_flags_t       ins_flags,
    input  wire logic [RA_W-1:0] id_rs1,
    input  wire logic [RA_W-1:0] id_rs2,
    output logic                 raw_hit,
    output logic                 load_use_hit,
    output logic                 mem_memop,
    output logic                 ex_beq
);

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        sb_flags_t       f;
    } entry_t;

    entry_t [2:0] r_sb;
    entry_t       w_ins;
    logic   [2:0] w_src_match;
    logic   [2:0] w_raw;
    logic         w_unused_wb;

    always_comb begin
        w_ins       = '0;
        w_ins.valid = ins_valid;
        w_ins.rd    = ins_rd;
        w_ins.f     = ins_flags;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else if (advance) begin
            r_sb <= {r_sb[SB_MEM], r_sb[SB_EX], w_ins};
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_match
        assign w_src_match[gi] = (r_sb[gi].rd == id_rs1) || (r_sb[gi].rd == id_rs2);
        assign w_raw[gi]       = r_sb[gi].valid && r_sb[gi].f.regwr && w_src_match[gi];
    end

    assign raw_hit      = |w_raw;
    assign load_use_hit = r_sb[SB_EX].valid && r_sb[SB_EX].f.rdmem && w_src_match[SB_EX];
    assign mem_memop    = r_sb[SB_MEM].valid && (r_sb[SB_MEM].f.rdmem || r_sb[SB_MEM].f.memwr);
    assign ex_beq       = r_sb[SB_EX].valid && r_sb[SB_EX].f.beq;

    // The WB entry only matters for register-write matching
    assign w_unused_wb = &{1'b0, r_sb[SB_WB].f.beq, r_sb[SB_WB].f.rdmem, r_sb[SB_WB].f.memwr};

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Issue/hazard controller for the IF/ID/EX/MEM-WB pipeline.
//             Tracks in-flight writers, sequences LD/ST with a ready
//             handshake and drives stall, flush, bubble and PC select.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous reset, active-high
//             bus  - pipe_hazard_ctrl_if.slave (ID fields, branch result,
//                    memory handshake, stall/flush/pc_sel/mem_timeout)
//  Config   : HAZ_FORWARD_EN - when defined, ALU results are forwarded and
//             only load-use stalls; otherwise any in-flight writer of a
//             source register stalls ID.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W       = 3,
    parameter int FLUSH_CYC  = 1,
    parameter int MEM_TO_MAX = 15
) (
    input wire logic          clk,
    input wire logic          rst,
    pipe_hazard_ctrl_if.slave bus
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_flush_cnt;
    logic [3:0] r_to_cnt;

    logic      w_raw_hit;
    logic      w_lu_hit;
    logic      w_mem_memop;
    logic      w_ex_beq;
    logic      w_data_hit;
    logic      w_mem_req;
    logic      w_freeze;
    logic      w_in_flush;
    logic      w_br;
    logic      w_jmp;
    logic      w_data_stall;
    logic      w_ins_valid;
    logic      w_flush_done;
    sb_flags_t w_ins_flags;

    logic       w_o_mem_req;
    logic       w_o_stall;
    logic       w_o_flush;
    logic [1:0] w_o_pc_sel;
    logic       w_o_timeout;
    logic       w_unused_ok;

    assign w_ins_flags.beq   = bus.id_ctrl[CR_BEQ];
    assign w_ins_flags.rdmem = bus.id_ctrl[CR_RDMEM];
    assign w_ins_flags.memwr = bus.id_ctrl[CR_MEMWR];
    assign w_ins_flags.regwr = bus.id_ctrl[CR_REGWR];

    haz_scoreboard #(
        .RA_W (RA_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .advance      (!w_freeze),
        .ins_valid    (w_ins_valid),
        .ins_rd       (bus.id_rd),
        .ins_flags    (w_ins_flags),
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .raw_hit      (w_raw_hit),
        .load_use_hit (w_lu_hit),
        .mem_memop    (w_mem_memop),
        .ex_beq       (w_ex_beq)
    );

`ifdef HAZ_FORWARD_EN
    assign w_data_hit = w_lu_hit;
`else
    assign w_data_hit = w_raw_hit || w_lu_hit;
`endif

    // A pending LD/ST that is not ready freezes every stage, including EX,
    // so it outranks branch, jump and data-hazard handling. The cycle in
    // which MEM_WAIT sees mem_ready is an ordinary advancing cycle.
    assign w_in_flush   = (r_state == ST_FLUSH);
    assign w_mem_req    = w_mem_memop && !w_in_flush;
    assign w_freeze     = w_mem_req && !bus.mem_ready;
    assign w_br         = !w_freeze && !w_in_flush && bus.ex_br_taken && w_ex_beq;
    assign w_jmp        = !w_freeze && !w_in_flush && !w_br && bus.id_valid && bus.id_ctrl[CR_JMP];
    assign w_data_stall = !w_freeze && !w_in_flush && !w_br && !w_jmp && bus.id_valid && w_data_hit;
    // Wrong-path instructions (taken branch, flush window) and stalled ones become bubbles
    assign w_ins_valid  = bus.id_valid && !w_in_flush && !w_br && !w_data_stall;
    assign w_flush_done = (r_flush_cnt == 3'(FLUSH_CYC - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            if (w_in_flush && !w_flush_done) begin
                r_flush_cnt <= r_flush_cnt + 3'd1;
            end else begin
                r_flush_cnt <= '0;
            end
            if ((r_state == ST_MEM_WAIT) && w_freeze) begin
                r_to_cnt <= (r_to_cnt == 4'hF) ? 4'hF : r_to_cnt + 4'd1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else if (w_br) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_MEM_WAIT: begin
                if (!w_freeze) begin
                    w_state_nxt = w_br ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_flush_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_o_mem_req = 1'b0;
        w_o_stall   = 1'b0;
        w_o_flush   = 1'b0;
        w_o_pc_sel  = PC_SEL_NEXT;
        w_o_timeout = 1'b0;
        if (!rst) begin
            w_o_mem_req = w_mem_req;
            // Pulses once: the counter saturates past this value
            w_o_timeout = (r_state == ST_MEM_WAIT) && w_freeze
                          && (r_to_cnt == 4'(MEM_TO_MAX - 1));
            if (w_freeze) begin
                w_o_stall = 1'b1;
            end else if (w_in_flush) begin
                w_o_flush = 1'b1;
            end else if (w_br) begin
                w_o_pc_sel = PC_SEL_BEQ;
                w_o_flush  = 1'b1;
            end else if (w_jmp) begin
                w_o_pc_sel = PC_SEL_JMP;
                w_o_flush  = 1'b1;
            end else if (w_data_stall) begin
                w_o_stall = 1'b1;
            end
        end
    end

    assign bus.mem_req     = w_o_mem_req;
    assign bus.stall_if    = w_o_stall;
    assign bus.stall_id    = w_o_stall;
    assign bus.flush_id    = w_o_flush;
    assign bus.pc_sel      = w_o_pc_sel;
    assign bus.mem_timeout = w_o_timeout;

    // ALU op is carried for the datapath only; raw_hit is idle with forwarding
    assign w_unused_ok = &{1'b0, bus.id_ctrl[2:0], w_raw_hit};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             plus randomized traffic against an instruction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYC  = 2;
    localparam int MEM_TO_MAX = 15;
`ifdef HAZ_FORWARD_EN
    localparam int RAW_STALLS = 1;
    localparam int ALU_STALLS = 0;
`else
    localparam int RAW_STALLS = 3;
    localparam int ALU_STALLS = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(3)) bus ();

    pipe_hazard_ctrl #(
        .RA_W       (3),
        .FLUSH_CYC  (FLUSH_CYC),
        .MEM_TO_MAX (MEM_TO_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit       v;
        bit [7:0] ctrl;
        bit [2:0] rd;
    } ins_t;

    ins_t m_pipe[3];
    bit   m_waiting;     // controller is in its memory-wait state
    int   m_wait_n;      // wait cycles already completed
    int   m_flush_left;  // remaining squash cycles after a taken branch

    // Last observed DUT outputs and model stall decision
    bit       d_req, d_stall, d_flush, d_to;
    bit [1:0] d_pc;
    bit       g_e_stall;

    task automatic step(input bit r, input bit v, input bit [7:0] c, input bit [2:0] rd,
                        input bit [2:0] rs1, input bit [2:0] rs2, input bit br, input bit rdy);
        bit       memop, in_flush, req, freeze, taken, jump, lu, hz, hstall;
        bit       e_req, e_stall, e_flush, e_to;
        bit [1:0] e_pc;
        ins_t     nw;
        rst             = r;
        bus.id_valid    = v;
        bus.id_ctrl     = c;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.ex_br_taken = br;
        bus.mem_ready   = rdy;

        memop    = m_pipe[1].v && (m_pipe[1].ctrl[4] || m_pipe[1].ctrl[5]);
        in_flush = (m_flush_left > 0);
        req      = memop && !in_flush;
        freeze   = req && !rdy;
        taken    = !freeze && !in_flush && br && m_pipe[0].v && m_pipe[0].ctrl[3];
        jump     = !freeze && !in_flush && !taken && v && c[7];
        lu       = m_pipe[0].v && m_pipe[0].ctrl[4] && (m_pipe[0].rd == rs1 || m_pipe[0].rd == rs2);
        hz       = lu;
`ifndef HAZ_FORWARD_EN
        for (int i = 0; i < 3; i++)
            if (m_pipe[i].v && m_pipe[i].ctrl[6] && (m_pipe[i].rd == rs1 || m_pipe[i].rd == rs2))
                hz = 1'b1;
`endif
        hstall  = !freeze && !in_flush && !taken && !jump && v && hz;
        e_req   = !r && req;
        e_stall = !r && (freeze || hstall);
        e_flush = !r && (in_flush || taken || jump);
        e_pc    = r ? 2'd0 : (taken ? 2'd2 : (jump ? 2'd1 : 2'd0));
        e_to    = !r && m_waiting && !rdy && (m_wait_n + 1 == MEM_TO_MAX);
        g_e_stall = e_stall;

        @(negedge clk);
        check_eq("mem_req",     bus.mem_req,     e_req);
        check_eq("stall_if",    bus.stall_if,    e_stall);
        check_eq("stall_id",    bus.stall_id,    e_stall);
        check_eq("flush_id",    bus.flush_id,    e_flush);
        check_eq("pc_sel",      bus.pc_sel,      e_pc);
        check_eq("mem_timeout", bus.mem_timeout, e_to);
        d_req   = bus.mem_req;
        d_stall = bus.stall_if;
        d_flush = bus.flush_id;
        d_pc    = bus.pc_sel;
        d_to    = bus.mem_timeout;

        if (r) begin
            for (int i = 0; i < 3; i++) m_pipe[i] = '{v: 1'b0, ctrl: 8'h00, rd: 3'd0};
            m_waiting    = 1'b0;
            m_wait_n     = 0;
            m_flush_left = 0;
        end else if (freeze) begin
            if (m_waiting) m_wait_n++;
            m_waiting = 1'b1;
        end else begin
            nw.v    = v && !in_flush && !taken && !hstall;
            nw.ctrl = nw.v ? c : 8'h00;
            nw.rd   = rd;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = nw;
            m_flush_left = in_flush ? m_flush_left - 1 : (taken ? FLUSH_CYC : 0);
            m_waiting = 1'b0;
            m_wait_n  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input bit rdy);
        step(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0);
    endtask

    int cnt_a, cnt_b, cnt_c;

    initial begin
        rst             = 1'b1;
        bus.id_valid    = 1'b0;
        bus.id_ctrl     = 8'h00;
        bus.id_rd       = 3'd0;
        bus.id_rs1      = 3'd0;
        bus.id_rs2      = 3'd0;
        bus.ex_br_taken = 1'b0;
        bus.mem_ready   = 1'b1;
        @(posedge clk);
        #1;

        // Load followed by a dependent ADD
        do_reset();
        step(1'b0, 1'b1, 8'h50, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        cnt_a = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 8'h40, 3'd2, 3'd1, 3'd3, 1'b0, 1'b1);
            if (d_stall) cnt_a++;
            if (!g_e_stall) break;
        end
        check_eq("t1_stall_cycles", cnt_a, RAW_STALLS);

        // Store with mem_ready low for 5 cycles
        do_reset();
        step(1'b0, 1'b1, 8'h20, 3'd0, 3'd5, 3'd6, 1'b0, 1'b1);
        nop(1'b1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 9; k++) begin
            nop((k >= 5) ? 1'b1 : 1'b0);
            cnt_a += d_req;
            cnt_b += d_stall;
            cnt_c += d_to;
        end
        check_eq("t2_req_cycles", cnt_a, 6);
        check_eq("t2_stall_cycles", cnt_b, 5);
        check_eq("t2_timeouts", cnt_c, 0);

        // Taken branch with FLUSH_CYC = 2
        do_reset();
        step(1'b0, 1'b1, 8'h08, 3'd0, 3'd5, 3'd6, 1'b0, 1'b1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'h40, 3'd7, 3'd6, 3'd6, (k == 0), 1'b1);
            cnt_a += (d_pc == 2'd2);
            cnt_b += d_flush;
            cnt_c += d_stall;
        end
        check_eq("t3_pcsel2_cycles", cnt_a, 1);
        check_eq("t3_flush_cycles", cnt_b, 3);
        check_eq("t3_stall_cycles", cnt_c, 0);

        // Jump in ID while a load-use hazard is present
        do_reset();
        step(1'b0, 1'b1, 8'h50, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h80, 3'd0, 3'd1, 3'd1, 1'b0, 1'b1);
        check_eq("t4_pc_sel", d_pc, 1);
        check_eq("t4_flush", d_flush, 1);
        check_eq("t4_stall", d_stall, 0);

        // ALU result consumed by the next instruction
        do_reset();
        step(1'b0, 1'b1, 8'h40, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
        cnt_a = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 8'h44, 3'd4, 3'd1, 3'd1, 1'b0, 1'b1);
            if (d_stall) cnt_a++;
            if (!g_e_stall) break;
        end
        check_eq("t5_stall_cycles", cnt_a, ALU_STALLS);

        // Long memory wait interrupted by reset
        do_reset();
        step(1'b0, 1'b1, 8'h50, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1);
        nop(1'b1);
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            step((k == 18), 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
            cnt_a += d_to;
        end
        check_eq("t6_timeouts", cnt_a, 1);
        check_eq("t6_req_after_rst", d_req, 0);
        check_eq("t6_stall_after_rst", d_stall, 0);

        // Randomized traffic, small register range to provoke hazards
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 8),
                 8'($urandom),
                 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
